toccata_capture_gain: RTL and testbench
=======================================

# toccata_capture_gain

Capture-side (ADC → host) input gain stage for the Toccata sound path. It takes 16-bit signed stereo record samples with a valid strobe and applies a per-channel programmable gain of 0 to +22.5 dB in 1.5 dB steps. The result is saturated to 16 bits, and a latched per-channel overrange level is reported for the Toccata status register. Gain changes can be deferred to zero crossings to avoid clicks. The block sits between the codec-side capture deserializer and the capture FIFO.

## Interface
- `ZC_TIMEOUT`, 256: maximum number of accepted samples a pending gain change waits for a zero crossing.
- `clk` in 1: the single system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `sample_valid_in` in 1: input sample strobe, one sample pair per asserted cycle.
- `audio_in_left`, `audio_in_right` in 16 signed: capture samples.
- `gain_left`, `gain_right` in 4: gain code k, gain = 1.5·k dB.
- `overrange_clr` in 1: single-cycle pulse that clears both overrange latches.
- `sample_valid_out` out 1: output strobe.
- `audio_out_left`, `audio_out_right` out 16 signed: gained, saturated samples.
- `overrange_left`, `overrange_right` out 2: latched maximum level code since the last clear.

## Operation
- Gain LUT: unsigned Q4.12, `factor[k] = round(4096·10^(1.5k/20))`.
  - Examples: `factor[0]=4096`, `factor[4]=8173`, `factor[15]=54621`.
- Arithmetic: `p = in × factor` (33-bit signed), then `y = p >>> 12` (arithmetic shift, floor).
- Saturation: `y` is clamped to [-32768, 32767].
- Overrange classification uses `|y|` before saturation:
  - `<29204` → 00 (below -1 dB)
  - `<32768` → 01 (-1 to 0 dB)
  - `≤36765` → 10 (0 to +1 dB)
  - otherwise → 11 (clipped)
- Overrange latch: each output sample sets `latch = max(latch, code)`.
  - `overrange_clr` zeroes the latch.
  - If a clear and a classification occur in the same cycle, the latch takes the new code (clear first, then max).
- Active gain: each channel holds an active gain code and a target gain code. The target follows `gain_x` continuously.
- Per-channel FSM, advancing only on accepted samples:
  - IDLE: active == target. When target ≠ active on an accepted sample, go to WAIT_ZC with `cnt = 1`. That triggering sample still uses the old gain.
  - WAIT_ZC: on each accepted sample, check for a zero crossing, meaning the current sample is 0 or its sign differs from the previous accepted sample.
    - If a zero crossing occurs, or if `cnt == ZC_TIMEOUT`, copy target to active and return to IDLE. This sample uses the new gain.
    - Otherwise increment `cnt`.
  - If the target changes again while in WAIT_ZC, only the target updates; `cnt` is not restarted.
  - If target returns to active while in WAIT_ZC, go back to IDLE with no gain change.
- Previous-sample register: updated on every accepted sample. Reset value is 0.

## Timing
- Pipeline has two stages:
  - S1 registers the product.
  - S2 registers the shift, saturation and classification.
- Latency: `sample_valid_in` at cycle n gives `sample_valid_out` and data at cycle n+2.
- Throughput: one sample pair per cycle, with no backpressure.
- `sample_valid_out` is high for exactly one cycle per accepted input.
- `audio_out_*` holds its value between strobes.
- The overrange latch updates in the same cycle that `sample_valid_out` rises.
- Reset values, applied immediately on `rst_n` low, mid-stream included:
  - all outputs 0, `sample_valid_out` 0, overrange 00;
  - active and target gains 0;
  - FSM in IDLE, `cnt` 0;
  - pipeline valid bits cleared, so in-flight samples are dropped.
- Reset release is synchronized externally; no output strobe appears before the first accepted sample after release plus 2 cycles.

## Configuration
- `TOCCATA_CAPTURE_ZC_EN` defined: zero-cross deferral FSM as described above.
- `TOCCATA_CAPTURE_ZC_EN` undefined:
  - no FSM and no counter;
  - active gain = `gain_x`, sampled on each accepted sample;
  - `ZC_TIMEOUT` is ignored.

## Structure
- Package `toccata_pkg` holds:
  - the 16-entry gain factor LUT constant;
  - threshold constants 29204, 32768 and 36765;
  - typedef `overrange_t` (2-bit enum: BELOW_M1DB, M1_0DB, P0_1DB, CLIPPED).
- Sub-module `toccata_capture_chan` covers one channel: FSM, multiply, saturate, classify and latch. It is instantiated twice. The top level shares valid-pipeline tracking and the clear signal.

## Test plan
- Gain 0, in L = 1000 / R = -1000 at cycle 0 → out 1000 / -1000 at cycle 2, overrange 00.
- Gain 15:
  - in 3000 → 32767 with overrange 11;
  - in -3000 → -32768 with overrange 11;
  - `overrange_clr` pulse → 00; clear coincident with a clipping sample → 11.
- Gain 4, in 16000 → 31925, overrange 01; a following sample 100 → 199, and the latch stays 01.
- ZC_EN, gain changes 0→4, input alternates +100/-100 → the next sample after the change is 100 (old gain), the next sign-flip sample is -200 (new gain). Same change with input held at +100 → 100 for 256 samples, then 199.
- ZC_EN off, same step → 199 on the first sample accepted after `gain_x` changes.
- `rst_n` low while the pipeline is full → outputs, valid and latches 0 at once; after release, gain 0 produces `in = out`.

Source files
------------

// File: rtl/toccata_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : toccata_pkg
//  Description : Shared constants and types for the Toccata capture gain
//                stage: Q4.12 gain factor table, overrange thresholds,
//                overrange level codes and zero-cross FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package toccata_pkg;

    // Gain factors, unsigned Q4.12: round(4096 * 10^(1.5*k/20)), k = 0..15
    localparam logic [15:0] c_gain_lut [0:15] = '{
        16'd4096,  16'd4868,  16'd5786,  16'd6876,
        16'd8173,  16'd9713,  16'd11544, 16'd13720,
        16'd16306, 16'd19380, 16'd23034, 16'd27375,
        16'd32536, 16'd38669, 16'd45958, 16'd54621
    };

    // Magnitude thresholds applied to the unsaturated, shifted result
    localparam logic [20:0] c_thr_m1db  = 21'd29204;  // -1 dBFS
    localparam logic [20:0] c_thr_0db   = 21'd32768;  //  0 dBFS
    localparam logic [20:0] c_thr_p1db  = 21'd36765;  // +1 dBFS

    typedef enum logic [1:0] {
        BELOW_M1DB = 2'b00,
        M1_0DB     = 2'b01,
        P0_1DB     = 2'b10,
        CLIPPED    = 2'b11
    } overrange_t;

    typedef enum logic [0:0] {
        ZC_IDLE = 1'b0,
        ZC_WAIT = 1'b1
    } zc_state_t;

    // Map the magnitude of the unsaturated result to its overrange level
    function automatic overrange_t classify(input logic [20:0] mag);
        if (mag < c_thr_m1db)
            classify = BELOW_M1DB;
        else if (mag < c_thr_0db)
            classify = M1_0DB;
        else if (mag <= c_thr_p1db)
            classify = P0_1DB;
        else
            classify = CLIPPED;
    endfunction

endpackage
`default_nettype wire

// File: rtl/toccata_capture_chan.sv
`default_nettype none
// ============================================================================
//  Module      : toccata_capture_chan
//  Description : One capture channel: active-gain selection (optional
//                zero-cross deferral), Q4.12 multiply, floor shift,
//                16-bit saturation and latched overrange level.
//                Optional feature macro: TOCCATA_CAPTURE_ZC_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module toccata_capture_chan
    import toccata_pkg::*;
#(
    parameter int ZC_TIMEOUT = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_valid,   // sample accepted this cycle
    input  logic               i_v1,      // product register holds a sample
    input  logic               i_clr,     // clear overrange latch
    input  logic signed [15:0] i_sample,
    input  logic [3:0]         i_gain,
    output logic signed [15:0] o_sample,
    output logic [1:0]         o_ovr
);

    logic [3:0]         w_gain;
    logic signed [32:0] w_a;
    logic signed [32:0] w_b;
    logic signed [32:0] w_prod;
    logic signed [32:0] r_prod;
    logic signed [20:0] w_y;
    logic [20:0]        w_mag;
    logic signed [15:0] w_sat;
    logic [1:0]         w_code;
    logic [1:0]         w_ovr_base;

`ifdef TOCCATA_CAPTURE_ZC_EN
    localparam int CNT_W = $clog2(ZC_TIMEOUT + 1);

    zc_state_t          r_state;
    logic [3:0]         r_active;
    logic [3:0]         r_target;
    logic [CNT_W-1:0]   r_cnt;
    logic signed [15:0] r_prev;
    logic               w_zc;
    logic               w_cnt_done;

    assign w_zc       = (i_sample == 16'sd0) || (i_sample[15] != r_prev[15]);
    assign w_cnt_done = (r_cnt == CNT_W'(ZC_TIMEOUT));

    // The sample that completes a pending change already uses the new gain
    always_comb begin
        w_gain = r_active;
        if (r_state == ZC_WAIT && r_target != r_active && (w_zc || w_cnt_done))
            w_gain = r_target;
    end

    // Zero-cross deferral FSM; advances only on accepted samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ZC_IDLE;
            r_active <= 4'd0;
            r_target <= 4'd0;
            r_cnt    <= '0;
            r_prev   <= 16'sd0;
        end else begin
            r_target <= i_gain;
            if (i_valid) begin
                r_prev <= i_sample;
                case (r_state)
                    ZC_IDLE: begin
                        if (r_target != r_active) begin
                            r_state <= ZC_WAIT;
                            r_cnt   <= CNT_W'(1);
                        end
                    end
                    ZC_WAIT: begin
                        if (r_target == r_active) begin
                            r_state <= ZC_IDLE;
                            r_cnt   <= '0;
                        end else if (w_zc || w_cnt_done) begin
                            r_active <= r_target;
                            r_state  <= ZC_IDLE;
                            r_cnt    <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= ZC_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end
`else
    // Gain follows the control input directly on every accepted sample
    always_comb begin
        w_gain = i_gain;
    end
`endif

    // Both operands widened to 33 bits so the product is exact
    assign w_a    = {{17{i_sample[15]}}, i_sample};
    assign w_b    = {17'd0, c_gain_lut[w_gain]};
    assign w_prod = w_a * w_b;

    // S1: register the product of each accepted sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_prod <= 33'sd0;
        else if (i_valid)
            r_prod <= w_prod;
    end

    // Dropping the 12 fraction bits is an arithmetic shift with floor
    assign w_y   = r_prod[32:12];
    assign w_mag = w_y[20] ? 21'(-w_y) : 21'(w_y);

    always_comb begin
        w_sat = w_y[15:0];
        if (w_y > 21'sd32767)
            w_sat = 16'sh7FFF;
        else if (w_y < -21'sd32768)
            w_sat = 16'sh8000;
    end

    assign w_code     = classify(w_mag);
    assign w_ovr_base = i_clr ? 2'b00 : o_ovr;

    // S2: saturated output and overrange latch (clear applies before max)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_sample <= 16'sd0;
            o_ovr    <= 2'b00;
        end else if (i_v1) begin
            o_sample <= w_sat;
            o_ovr    <= (w_code > w_ovr_base) ? w_code : w_ovr_base;
        end else if (i_clr) begin
            o_ovr    <= 2'b00;
        end
    end

endmodule
`default_nettype wire

// File: rtl/toccata_capture_gain.sv
`default_nettype none
// ============================================================================
//  Module      : toccata_capture_gain
//  Description : Stereo capture gain stage (0..+22.5 dB, 1.5 dB steps) with
//                16-bit saturation and latched overrange levels. Two-stage
//                pipeline, one sample pair per cycle, latency 2.
//                Optional feature macro: TOCCATA_CAPTURE_ZC_EN (zero-cross
//                deferred gain changes with ZC_TIMEOUT sample timeout)
//  Revision    : 1.0 - initial release
// ============================================================================
module toccata_capture_gain
    import toccata_pkg::*;
#(
    parameter int ZC_TIMEOUT = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_valid_in,
    input  logic signed [15:0] audio_in_left,
    input  logic signed [15:0] audio_in_right,
    input  logic [3:0]         gain_left,
    input  logic [3:0]         gain_right,
    input  logic               overrange_clr,
    output logic               sample_valid_out,
    output logic signed [15:0] audio_out_left,
    output logic signed [15:0] audio_out_right,
    output logic [1:0]         overrange_left,
    output logic [1:0]         overrange_right
);

    logic r_v1;
    logic r_v2;

    // Valid tracking shared by both channels; reset drops in-flight samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            r_v1 <= sample_valid_in;
            r_v2 <= r_v1;
        end
    end

    assign sample_valid_out = r_v2;

    toccata_capture_chan #(
        .ZC_TIMEOUT (ZC_TIMEOUT)
    ) u_chan_left (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (sample_valid_in),
        .i_v1     (r_v1),
        .i_clr    (overrange_clr),
        .i_sample (audio_in_left),
        .i_gain   (gain_left),
        .o_sample (audio_out_left),
        .o_ovr    (overrange_left)
    );

    toccata_capture_chan #(
        .ZC_TIMEOUT (ZC_TIMEOUT)
    ) u_chan_right (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (sample_valid_in),
        .i_v1     (r_v1),
        .i_clr    (overrange_clr),
        .i_sample (audio_in_right),
        .i_gain   (gain_right),
        .o_sample (audio_out_right),
        .o_ovr    (overrange_right)
    );

endmodule
`default_nettype wire

// File: tb/tb_toccata_capture_gain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_toccata_capture_gain
//  Description : Directed self-checking bench for toccata_capture_gain with
//                hand-computed expected values.
//                Optional feature macro: TOCCATA_CAPTURE_ZC_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_toccata_capture_gain;

    logic               clk;
    logic               rst_n;
    logic               sample_valid_in;
    logic signed [15:0] audio_in_left;
    logic signed [15:0] audio_in_right;
    logic [3:0]         gain_left;
    logic [3:0]         gain_right;
    logic               overrange_clr;
    logic               sample_valid_out;
    logic signed [15:0] audio_out_left;
    logic signed [15:0] audio_out_right;
    logic [1:0]         overrange_left;
    logic [1:0]         overrange_right;

    int checks = 0;
    int errors = 0;

    toccata_capture_gain #(
        .ZC_TIMEOUT (256)
    ) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sample_valid_in  (sample_valid_in),
        .audio_in_left    (audio_in_left),
        .audio_in_right   (audio_in_right),
        .gain_left        (gain_left),
        .gain_right       (gain_right),
        .overrange_clr    (overrange_clr),
        .sample_valid_out (sample_valid_out),
        .audio_out_left   (audio_out_left),
        .audio_out_right  (audio_out_right),
        .overrange_left   (overrange_left),
        .overrange_right  (overrange_right)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one pair, check nothing emerges at n+1, then check data at n+2
    task automatic run(input int l, input int r, input int el, input int er,
                       input int ovl, input int ovr);
        audio_in_left   = 16'(l);
        audio_in_right  = 16'(r);
        sample_valid_in = 1'b1;
        tick();
        sample_valid_in = 1'b0;
        chk("valid_n1", int'(sample_valid_out), 0);
        tick();
        chk("valid_n2", int'(sample_valid_out), 1);
        chk("out_l", int'(audio_out_left), el);
        chk("out_r", int'(audio_out_right), er);
        chk("ovr_l", int'(overrange_left), ovl);
        chk("ovr_r", int'(overrange_right), ovr);
    endtask

    task automatic clr_pulse();
        overrange_clr = 1'b1;
        tick();
        overrange_clr = 1'b0;
    endtask

    // Two zero samples let a (possibly deferred) gain change take effect
    task automatic settle();
        tick();
        run(0, 0, 0, 0, 0, 0);
        run(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n           = 1'b0;
        sample_valid_in = 1'b0;
        audio_in_left   = '0;
        audio_in_right  = '0;
        gain_left       = 4'd0;
        gain_right      = 4'd0;
        overrange_clr   = 1'b0;

        tick();
        chk("rst_valid", int'(sample_valid_out), 0);
        chk("rst_out_l", int'(audio_out_left), 0);
        chk("rst_out_r", int'(audio_out_right), 0);
        chk("rst_ovr_l", int'(overrange_left), 0);
        chk("rst_ovr_r", int'(overrange_right), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Unity gain and hold between strobes
        run(1000, -1000, 1000, -1000, 0, 0);
        tick();
        chk("strobe_one_cycle", int'(sample_valid_out), 0);
        chk("hold_l", int'(audio_out_left), 1000);

        // Maximum gain clips both polarities
        gain_left  = 4'd15;
        gain_right = 4'd15;
        settle();
        run(3000, -3000, 32767, -32768, 3, 3);

        clr_pulse();
        chk("clr_ovr_l", int'(overrange_left), 0);
        chk("clr_ovr_r", int'(overrange_right), 0);

        // Clear coincident with a clipping classification: new code wins
        audio_in_left   = 16'sd3000;
        audio_in_right  = -16'sd3000;
        sample_valid_in = 1'b1;
        tick();
        sample_valid_in = 1'b0;
        overrange_clr   = 1'b1;
        tick();
        overrange_clr   = 1'b0;
        chk("coinc_valid", int'(sample_valid_out), 1);
        chk("coinc_ovr_l", int'(overrange_left), 3);
        chk("coinc_ovr_r", int'(overrange_right), 3);

        // +6 dB: 16000*8173>>12 = 31925, -16000 -> -31926; latch stays 01
        clr_pulse();
        gain_left  = 4'd4;
        gain_right = 4'd4;
        settle();
        run(16000, -16000, 31925, -31926, 1, 1);
        run(100, -100, 199, -200, 1, 1);

        clr_pulse();
        gain_left  = 4'd0;
        gain_right = 4'd0;
        settle();
`ifdef TOCCATA_CAPTURE_ZC_EN
        // Alternating signs: trigger sample keeps old gain, flip uses new
        gain_left  = 4'd4;
        gain_right = 4'd4;
        tick();
        run(100, -100, 100, -100, 0, 0);
        run(-100, 100, -200, 199, 0, 0);

        // Held input: change waits out the full timeout
        gain_left  = 4'd0;
        gain_right = 4'd0;
        settle();
        gain_left  = 4'd4;
        gain_right = 4'd4;
        tick();
        for (int i = 0; i < 256; i++)
            run(100, 100, 100, 100, 0, 0);
        run(100, 100, 199, 199, 0, 0);
`else
        // Immediate gain: first sample after the change uses it
        gain_left  = 4'd4;
        gain_right = 4'd4;
        run(100, -100, 199, -200, 0, 0);
`endif

        // Reset with the pipeline full
        audio_in_left   = 16'sd32000;
        audio_in_right  = 16'sd32000;
        sample_valid_in = 1'b1;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", int'(sample_valid_out), 0);
        chk("midrst_out_l", int'(audio_out_left), 0);
        chk("midrst_out_r", int'(audio_out_right), 0);
        chk("midrst_ovr_l", int'(overrange_left), 0);
        chk("midrst_ovr_r", int'(overrange_right), 0);
        sample_valid_in = 1'b0;
        gain_left       = 4'd0;
        gain_right      = 4'd0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid_a", int'(sample_valid_out), 0);
        tick();
        chk("post_rst_valid_b", int'(sample_valid_out), 0);
        run(1234, -4321, 1234, -4321, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
